// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with KMP-style fallback computed from the
// live pattern register, runtime reload, Mealy/Moore match and saturating hit count.
module seq_detect_param #(
    parameter int PAT_W             = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0101,
    parameter int OVERLAP           = 1,
    parameter int MOORE             = 0,
    parameter int CNT_W             = 8,
    localparam int SW               = ($clog2(PAT_W) > 1) ? $clog2(PAT_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    state
);

    // Stream handshake: a bit is accepted on any rising edge with in_valid=1 and
    // pat_load=0. There is no back-pressure; pat_load wins over in_valid.

    logic [PAT_W-1:0] pat_q;
    logic [SW-1:0]    state_q;
    logic [SW-1:0]    state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             match_q;
    logic [PAT_W-1:0] cand;
    logic             hit;
    logic             accept;
    int               k;
    int               nk;

    assign accept = in_valid & ~pat_load;

    // Held bits always equal the first k pattern bits, so the candidate is that
    // prefix with the new bit appended, right-aligned in a PAT_W vector.
    always_comb begin
        k    = int'(state_q);
        nk   = 0;
        cand = ((pat_q >> (PAT_W - k)) << 1) | PAT_W'(in);
        hit  = (k == PAT_W - 1) && (cand == pat_q);
        for (int j = 1; j < PAT_W; j++) begin
            if ((j <= k + 1) &&
                ((cand & ({PAT_W{1'b1}} >> (PAT_W - j))) == (pat_q >> (PAT_W - j)))) begin
                nk = j;
            end
        end
        if (hit && (OVERLAP == 0)) begin
            nk = 0;
        end
        state_d = SW'(nk);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= PATTERN;
            state_q <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else if (pat_load) begin
            pat_q   <= pat_in;
            state_q <= '0;
            match_q <= 1'b0;
        end else if (in_valid) begin
            state_q <= state_d;
            match_q <= hit;
            if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign match     = (MOORE != 0) ? match_q : (accept & hit);
    assign match_cnt = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four parameter variants share one stimulus
// stream; each check is an immediate assertion against hand-computed values.
module tb_seq_detect_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       ser_in;
  logic       pat_load;
  logic [3:0] pat_in;

  logic       m0, m1, m2, m3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  logic [1:0] s0, s1, s2, s3;

  int vectors = 0;
  int miscompares = 0;

  seq_detect_param u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(ser_in), .pat_load(pat_load),
    .pat_in(pat_in), .match(m0), .match_cnt(c0), .state(s0)
  );

  seq_detect_param #(.OVERLAP(0)) u_novl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(ser_in), .pat_load(pat_load),
    .pat_in(pat_in), .match(m1), .match_cnt(c1), .state(s1)
  );

  seq_detect_param #(.MOORE(1)) u_moore (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(ser_in), .pat_load(pat_load),
    .pat_in(pat_in), .match(m2), .match_cnt(c2), .state(s2)
  );

  seq_detect_param #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(ser_in), .pat_load(pat_load),
    .pat_in(pat_in), .match(m3), .match_cnt(c3), .state(s3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    in_valid = v;
    ser_in   = b;
    pat_load = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    pat_load = 1'b0;
    ser_in   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Test 1/2/3 stream 0,1,0,1,0,1 with expected per-bit results
  logic t1_bits[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int   t1_s0[6]     = '{1, 2, 3, 2, 3, 2};
  int   t1_s1[6]     = '{1, 2, 3, 0, 1, 2};
  logic t1_m0[6]     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic t1_m1[6]     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic t1_m2pre[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic t1_m2post[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Test 4 stream with idle gaps
  logic t4_bits[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int   t4_s0[4]   = '{1, 2, 3, 2};

  // Test 6 stream after loading 1101: 1,1,0,1 then (1,0,1) x4
  logic t6_bits[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int   t6_s0[16]   = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1};

  initial begin
    int exp_c0;
    int exp_c3;
    logic exp_hit;

    rst      = 1'b1;
    in_valid = 1'b0;
    ser_in   = 1'b0;
    pat_load = 1'b0;
    pat_in   = 4'b0000;

    // Reset state
    do_reset();
    #1;
    check("rst_state", 32'(s0), 0);
    check("rst_cnt", 32'(c0), 0);
    check("rst_match", 32'(m0), 0);
    check("rst_moore_match", 32'(m2), 0);
    check("rst_sat_cnt", 32'(c3), 0);

    // Tests 1-3: overlapping, non-overlapping and Moore on 010101
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, t1_bits[i]);
      check($sformatf("t1_mealy_match_%0d", i), 32'(m0), 32'(t1_m0[i]));
      check($sformatf("t2_novl_match_%0d", i), 32'(m1), 32'(t1_m1[i]));
      check($sformatf("t3_moore_pre_%0d", i), 32'(m2), 32'(t1_m2pre[i]));
      tick();
      check($sformatf("t1_state_%0d", i), 32'(s0), 32'(t1_s0[i]));
      check($sformatf("t2_novl_state_%0d", i), 32'(s1), 32'(t1_s1[i]));
      check($sformatf("t3_moore_post_%0d", i), 32'(m2), 32'(t1_m2post[i]));
    end
    check("t1_cnt", 32'(c0), 2);
    check("t2_novl_cnt", 32'(c1), 1);
    check("t3_moore_cnt", 32'(c2), 2);
    check("t1_sat_cnt", 32'(c3), 2);

    // Test 4: idle gaps of 3 cycles between bits
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t4_bits[i]);
      check($sformatf("t4_match_%0d", i), 32'(m0), (i == 3) ? 1 : 0);
      tick();
      check($sformatf("t4_state_%0d", i), 32'(s0), 32'(t4_s0[i]));
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'($urandom_range(0, 1)));
          check($sformatf("t4_idle_match_%0d_%0d", i, g), 32'(m0), 0);
          tick();
          check($sformatf("t4_idle_state_%0d_%0d", i, g), 32'(s0), 32'(t4_s0[i]));
        end
      end
    end
    check("t4_cnt", 32'(c0), 1);

    // Test 5: asynchronous reset mid-cycle after 0,1,0
    do_reset();
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b1); tick();
    drive(1'b1, 1'b0); tick();
    check("t5_state_pre", 32'(s0), 3);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("t5_async_state", 32'(s0), 0);
    check("t5_async_moore_state", 32'(s2), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1);
    check("t5_no_match", 32'(m0), 0);
    tick();
    check("t5_state_post", 32'(s0), 0);
    check("t5_cnt", 32'(c0), 0);

    // Test 6: load 1101 while a 0101 hit is pending, then five hits
    do_reset();
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b1); tick();
    check("t6_state_two", 32'(s0), 2);
    drive(1'b1, 1'b0); tick();
    @(negedge clk);
    pat_load = 1'b1;
    pat_in   = 4'b1101;
    in_valid = 1'b1;
    ser_in   = 1'b1;
    #1;
    check("t6_load_no_match", 32'(m0), 0);
    tick();
    check("t6_load_state", 32'(s0), 0);
    check("t6_load_cnt", 32'(c0), 0);
    exp_c0 = 0;
    exp_c3 = 0;
    for (int i = 0; i < 16; i++) begin
      exp_hit = (i % 3 == 0) && (i > 0);
      drive(1'b1, t6_bits[i]);
      check($sformatf("t6_match_%0d", i), 32'(m0), 32'(exp_hit));
      tick();
      if (exp_hit) begin
        exp_c0++;
        if (exp_c3 < 3) exp_c3++;
      end
      check($sformatf("t6_state_%0d", i), 32'(s0), 32'(t6_s0[i]));
      check($sformatf("t6_cnt_%0d", i), 32'(c0), 32'(exp_c0));
      check($sformatf("t6_sat_cnt_%0d", i), 32'(c3), 32'(exp_c3));
    end
    check("t6_moore_hit", 32'(m2), 1);
    @(negedge clk);
    pat_load = 1'b1;
    pat_in   = 4'b0101;
    in_valid = 1'b0;
    tick();
    check("t6_reload_moore_clear", 32'(m2), 0);
    check("t6_reload_state", 32'(s0), 0);
    check("t6_reload_cnt_kept", 32'(c0), 5);
    check("t6_reload_sat_kept", 32'(c3), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
